sram_port_adapter: RTL
======================

SRAM_PORT_ADAPTER -- requirements
Module: sram_port_adapter

Interface
REQ-001 SHALL have parameter p_data_nbits, default 32, SRAM word width.
REQ-002 SHALL have parameter p_num_entries, default 256, SRAM depth.
REQ-003 SHALL derive c_addr_nbits = $clog2(p_num_entries) and c_data_nbytes = (p_data_nbits+7)/8.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  reset, synchronous, active-low.
REQ-006 req_val  in  1  request valid.
REQ-007 req_rdy  out  1  request ready.
REQ-008 req_type  in  1  0 = read, 1 = write.
REQ-009 req_addr  in  c_addr_nbits  word address.
REQ-010 req_data  in  p_data_nbits  write data.
REQ-011 req_byte_en  in  c_data_nbytes  write byte enables.
REQ-012 resp_val  out  1  response valid.
REQ-013 resp_rdy  in  1  response ready.
REQ-014 resp_type  out  1  type of the request that produced the response.
REQ-015 resp_data  out  p_data_nbits  read data; zero for writes.
REQ-016 sram_read_en  out  1  SRAM read enable.
REQ-017 sram_read_addr  out  c_addr_nbits  SRAM read address.
REQ-018 sram_read_data  in  p_data_nbits  SRAM read data, valid the cycle after sram_read_en.
REQ-019 sram_write_en  out  1  SRAM write enable.
REQ-020 sram_write_byte_en  out  c_data_nbytes  SRAM byte enables.
REQ-021 sram_write_addr  out  c_addr_nbits  SRAM write address.
REQ-022 sram_write_data  out  p_data_nbits  SRAM write data.

Function
REQ-023 Request fire (req_fire) SHALL be req_val && req_rdy. Response fire (resp_fire) SHALL be resp_val && resp_rdy.
REQ-024 In a req_fire cycle, sram_read_en SHALL be !req_type and sram_write_en SHALL be req_type. Both SHALL be 0 in all other cycles, and they SHALL never be 1 together.
REQ-025 sram_read_addr and sram_write_addr SHALL equal req_addr combinationally. sram_write_data SHALL equal req_data and sram_write_byte_en SHALL equal req_byte_en.
REQ-026 A one-entry in-flight register (inflight_val, inflight_type) SHALL load on req_fire and clear otherwise.
REQ-027 When inflight_val is set, the in-flight result SHALL be enqueued into a 2-entry FIFO response queue at the next edge:
  - read: the sram_read_data value.
  - write: zero data.
REQ-028 Latency: a request firing in cycle N SHALL give resp_val in cycle N+2 at the earliest. Responses SHALL leave in request order.
REQ-029 resp_val SHALL be 1 iff the queue is non-empty; resp_type and resp_data SHALL present the queue head.
REQ-030 req_rdy SHALL be 1 iff reset is deasserted (high) and (q_count + inflight_val − resp_fire) < 2. This is the only combinational path from resp_rdy.
REQ-031 Invariant: q_count + inflight_val ≤ 2 at every edge, so the queue never overflows.
REQ-032 Simultaneous enqueue and dequeue SHALL leave q_count unchanged and keep FIFO order, including when q_count = 2.
REQ-033 With resp_rdy held at 1, the block SHALL sustain one request per cycle.
REQ-034 With resp_rdy held at 0, the block SHALL accept exactly 2 requests, then hold req_rdy at 0 until a response dequeues.
REQ-035 A write with req_byte_en = 0 SHALL still assert sram_write_en and produce a response.
REQ-036 Queue pointers SHALL wrap modulo 2. q_count SHALL be 2 bits wide, range 0..2.

Reset
REQ-037 While reset = 0 at a rising edge, the block SHALL clear: inflight_val, q_count, and the queue pointers.
REQ-038 While reset = 0, the following outputs SHALL be 0: req_rdy, resp_val, sram_read_en, sram_write_en.
REQ-039 Reset asserted mid-operation SHALL discard in-flight and queued responses without emitting them. An SRAM write already issued is not undone.
REQ-040 In the first cycle after reset deasserts, req_rdy SHALL be 1 and resp_val SHALL be 0.

Verification
REQ-041 Write addr 5 data 0xDEADBEEF byte_en 0xF, then read addr 5, resp_rdy = 1: responses are (type 1, data 0) at N+2, then (type 0, data 0xDEADBEEF) at N+3.
REQ-042 Byte-masked write: write 0x11223344 with 0xF, then 0xAABBCCDD with byte_en 0x5 to addr 3, then read addr 3 -> resp_data 0x11BB33DD.
REQ-043 Back-to-back reads of addresses 0..7 with resp_rdy = 1: req_rdy stays 1, 8 responses arrive in consecutive cycles, in order.
REQ-044 Backpressure: resp_rdy = 0 with 4 reads offered. Exactly 2 fire, then req_rdy = 0. Raise resp_rdy for one cycle: req_rdy rises in that same cycle, first response dequeued.
REQ-045 Reset pulled low for one cycle while q_count = 2 and a read is in flight: next cycle resp_val = 0 and req_rdy = 1, and no stale response ever appears.
REQ-046 Every cycle, a monitor SHALL check: sram_read_en && sram_write_en never both 1, and q_count + inflight_val ≤ 2.

Source files
------------

// File: rtl/sram_port_adapter.sv
// sram_port_adapter
//
// Adapts a valid/ready request/response port onto a simple synchronous
// SRAM with separate read and write ports. Each accepted request is issued
// to the SRAM in the same cycle, sits in a one-entry in-flight register
// while the SRAM produces its read data, and is then pushed into a 2-entry
// response FIFO. Responses leave in request order.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. A sender may change its payload only after such a transfer;
// ready may depend combinationally on the receiver's own state and, for
// req_rdy, on resp_rdy (the only combinational path between the ports).
//
// Ports
//   clk                 clock, rising edge
//   reset               synchronous, active-low
//   req_val/req_rdy     request handshake
//   req_type            0 = read, 1 = write
//   req_addr            word address
//   req_data            write data
//   req_byte_en         write byte enables
//   resp_val/resp_rdy   response handshake
//   resp_type           type of the originating request
//   resp_data           read data (zero for writes)
//   sram_read_*         SRAM read port (data returns one cycle after enable)
//   sram_write_*        SRAM write port

module sram_port_adapter #(
  parameter int p_data_nbits  = 32,
  parameter int p_num_entries = 256,
  localparam int c_addr_nbits  = $clog2(p_num_entries),
  localparam int c_data_nbytes = (p_data_nbits + 7) / 8
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     req_val,
  output logic                     req_rdy,
  input  logic                     req_type,
  input  logic [c_addr_nbits-1:0]  req_addr,
  input  logic [p_data_nbits-1:0]  req_data,
  input  logic [c_data_nbytes-1:0] req_byte_en,

  output logic                     resp_val,
  input  logic                     resp_rdy,
  output logic                     resp_type,
  output logic [p_data_nbits-1:0]  resp_data,

  output logic                     sram_read_en,
  output logic [c_addr_nbits-1:0]  sram_read_addr,
  input  logic [p_data_nbits-1:0]  sram_read_data,

  output logic                     sram_write_en,
  output logic [c_data_nbytes-1:0] sram_write_byte_en,
  output logic [c_addr_nbits-1:0]  sram_write_addr,
  output logic [p_data_nbits-1:0]  sram_write_data
);

  // In-flight register: the request issued to the SRAM last cycle.
  logic inflight_val;
  logic inflight_type;

  // 2-entry response FIFO.
  logic                    q_type [2];
  logic [p_data_nbits-1:0] q_data [2];
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [1:0]              q_count;

  logic       req_fire;
  logic       resp_fire;
  logic [2:0] occupancy_next;

  assign req_fire  = req_val && req_rdy;
  assign resp_fire = resp_val && resp_rdy;

  // Slots still claimed after this cycle's dequeue. resp_fire implies
  // q_count >= 1, so the subtraction cannot underflow.
  assign occupancy_next = {1'b0, q_count} + {2'b00, inflight_val}
                        - {2'b00, resp_fire};

  // Accepting only when a slot is guaranteed keeps
  // q_count + inflight_val <= 2, so the FIFO never overflows.
  assign req_rdy = reset && (occupancy_next < 3'd2);

  assign resp_val  = reset && (q_count != 2'd0);
  assign resp_type = q_type[rd_ptr];
  assign resp_data = q_data[rd_ptr];

  assign sram_read_en       = req_fire && !req_type;
  assign sram_write_en      = req_fire && req_type;
  assign sram_read_addr     = req_addr;
  assign sram_write_addr    = req_addr;
  assign sram_write_data    = req_data;
  assign sram_write_byte_en = req_byte_en;

  // Control state: cleared by reset, which also drops any in-flight or
  // queued responses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      inflight_val <= 1'b0;
      q_count      <= 2'd0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
    end else begin
      inflight_val <= req_fire;
      if (inflight_val) wr_ptr <= ~wr_ptr;
      if (resp_fire)    rd_ptr <= ~rd_ptr;
      case ({inflight_val, resp_fire})
        2'b10:   q_count <= q_count + 2'd1;
        2'b01:   q_count <= q_count - 2'd1;
        default: q_count <= q_count;
      endcase
    end
  end

  // Datapath registers need no reset; they are only observed when the
  // matching valid bits are set.
  always_ff @(posedge clk) begin
    if (req_fire) inflight_type <= req_type;
    if (inflight_val) begin
      q_type[wr_ptr] <= inflight_type;
      // SRAM read data is valid in the in-flight cycle; writes return zero.
      q_data[wr_ptr] <= inflight_type ? '0 : sram_read_data;
    end
  end

endmodule
